// File: rtl/mcpu_soc_pkg.sv
// Shared MMIO bridge definitions: FSM encoding, window decode and bus defaults.
package mcpu_soc_pkg;

  localparam int unsigned MMIO_ADDR_W = 29;
  localparam int unsigned MMIO_DATA_W = 32;
  localparam int unsigned MMIO_BE_W   = 4;

  // 1 KiB-word windows: the window index is addr[28:10]
  localparam int unsigned WIN_LSB   = 10;
  localparam int unsigned WIN_IDX_W = MMIO_ADDR_W - WIN_LSB;

  localparam int unsigned WIN_LED_SW = 0;
  localparam int unsigned WIN_UART   = 1;

  // Issue window counter; ISSUE_CYCLES is limited to 1..15
  localparam int unsigned CNT_W = 4;

  // Address that decodes to no device while the bus is idle
  localparam logic [MMIO_ADDR_W-1:0] IDLE_ADDR_DEFAULT = 29'h1FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Window index of a word address
  function automatic logic [WIN_IDX_W-1:0] win_index(input logic [MMIO_ADDR_W-1:0] addr);
    return addr[MMIO_ADDR_W-1:WIN_LSB];
  endfunction

endpackage

// File: rtl/mcpu_soc_mmio_bridge.sv
// Core valid/ready request stream to single-strobe MMIO bus bridge.
// One transaction in flight; unmapped windows answer with an error and no bus activity.
module mcpu_soc_mmio_bridge
  import mcpu_soc_pkg::*;
#(
  parameter int unsigned               ISSUE_CYCLES = 1,
  parameter int unsigned               NUM_WINDOWS  = WIN_UART + 1,
  parameter logic [MMIO_ADDR_W-1:0]    IDLE_ADDR    = IDLE_ADDR_DEFAULT
) (
  input  logic                    clkrst_core_clk,
  input  logic                    clkrst_core_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MMIO_ADDR_W-1:0]  req_addr,
  input  logic [MMIO_DATA_W-1:0]  req_wdata,
  input  logic [MMIO_BE_W-1:0]    req_wren,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [MMIO_DATA_W-1:0]  resp_rdata,
  output logic                    resp_err,
  output logic [MMIO_ADDR_W-1:0]  mmio_addr,
  output logic [MMIO_DATA_W-1:0]  mmio_data_in,
  output logic [MMIO_BE_W-1:0]    mmio_wren,
  input  logic [MMIO_DATA_W-1:0]  mmio_data_out
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [MMIO_BE_W-1:0] wren_q;
  logic                 accept;
  logic                 mapped;

  // Ready in IDLE, or in RESP when the pending response is consumed this cycle
  assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && resp_ready);
  assign accept    = req_valid && req_ready;
  assign mapped    = win_index(req_addr) < WIN_IDX_W'(NUM_WINDOWS);

  // Bridge FSM with registered response and MMIO outputs
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      wren_q       <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mmio_addr    <= IDLE_ADDR;
      mmio_data_in <= '0;
      mmio_wren    <= '0;
    end else begin
      unique case (state)
        ST_ISSUE: begin
          if (cnt == '0) begin
            resp_rdata <= (|wren_q) ? '0 : mmio_data_out;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            mmio_addr  <= IDLE_ADDR;
            mmio_wren  <= '0;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
            // Strobe only on the final issue cycle
            if (cnt == CNT_W'(1)) mmio_wren <= wren_q;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // New request from IDLE or straight out of a consumed RESP
      if (accept) begin
        wren_q       <= req_wren;
        mmio_data_in <= req_wdata;
        if (mapped) begin
          state     <= ST_ISSUE;
          cnt       <= CNT_W'(ISSUE_CYCLES - 1);
          mmio_addr <= req_addr;
          mmio_wren <= (ISSUE_CYCLES == 1) ? req_wren : '0;
        end else begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcpu_soc_mmio_bridge.sv
// Scoreboard bench for mcpu_soc_mmio_bridge with directed vectors.
module tb_mcpu_soc_mmio_bridge;

  localparam int unsigned IC = 3;
  localparam logic [28:0] IDLE = 29'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [28:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wren = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [28:0] mmio_addr;
  logic [31:0] mmio_data_in;
  logic [3:0]  mmio_wren;
  logic [31:0] mmio_data_out;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [28:0] addr;
    logic [31:0] data;
    logic [3:0]  wren;
    int          cyc;
  } mmio_t;

  resp_t exp_resp[$];
  mmio_t exp_mmio[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int exp_busy = 0;
  bit seen     = 1'b0;

  mcpu_soc_mmio_bridge #(
    .ISSUE_CYCLES (IC),
    .NUM_WINDOWS  (2),
    .IDLE_ADDR    (IDLE)
  ) u_dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_wren          (req_wren),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .mmio_addr         (mmio_addr),
    .mmio_data_in      (mmio_data_in),
    .mmio_wren         (mmio_wren),
    .mmio_data_out     (mmio_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational MMIO device model: word 0 reads CAFE0001, others D0000000|addr
  assign mmio_data_out = (mmio_addr == 29'h0) ? 32'hCAFE_0001 : (32'hD000_0000 | {3'b000, mmio_addr});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: MMIO strobes and responses against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (mmio_addr != IDLE) busy_cnt++;
      if (mmio_wren != 4'b0) begin
        n_checks++;
        if (exp_mmio.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_wren: got wren %b addr %h at cycle %0d, none expected", mmio_wren, mmio_addr, cyc);
        end else begin
          mmio_t m;
          m = exp_mmio.pop_front();
          if (mmio_addr !== m.addr || mmio_data_in !== m.data || mmio_wren !== m.wren || cyc != m.cyc) begin
            n_fail++;
            $display("FAIL mmio_write: got addr %h data %h wren %b cyc %0d expected addr %h data %h wren %b cyc %0d",
                     mmio_addr, mmio_data_in, mmio_wren, cyc, m.addr, m.data, m.wren, m.cyc);
          end
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata %h err %b at cycle %0d, none expected", resp_rdata, resp_err, cyc);
        end else begin
          resp_t r;
          r = exp_resp[0];
          if (!seen) begin
            chk("resp_latency", 32'(cyc), 32'(r.cyc));
            seen = 1'b1;
          end
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
          if (resp_ready) begin
            void'(exp_resp.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Present one request, wait (bounded) for acceptance and post expectations
  task automatic send(input logic [28:0] a, input logic [31:0] d, input logic [3:0] w,
                      input logic [31:0] er, input logic ee, output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wren  = w;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        ok = 1'b1;
        exp_resp.push_back('{rdata: er, err: ee, cyc: acc + (ee ? 1 : int'(IC) + 1)});
        if (!ee) begin
          exp_busy += int'(IC);
          if (w != 4'b0) exp_mmio.push_back('{addr: a, data: d, wren: w, cyc: acc + int'(IC)});
        end
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: addr %h not accepted within 60 cycles", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  int a0, a1, a2, a3;
  bit got;

  initial begin
    // Reset values
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mmio_addr", {3'b0, mmio_addr}, {3'b0, IDLE});
    chk("rst_mmio_data_in", mmio_data_in, 32'd0);
    chk("rst_mmio_wren", {28'b0, mmio_wren}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed vectors, response always accepted
    send(29'h000_0000, 32'h0,         4'b0000, 32'hCAFE_0001, 1'b0, a0);
    send(29'h000_0400, 32'h0000_0041, 4'b0001, 32'h0,         1'b0, a0);
    send(29'h000_0800, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1, a0);
    send(29'h000_0401, 32'h0,         4'b0000, 32'hD000_0401, 1'b0, a0);
    send(29'h000_03FF, 32'h1234_5678, 4'b1010, 32'h0,         1'b0, a0);
    send(29'h1FFF_FFFF, 32'h0,        4'b0000, 32'h0,         1'b1, a0);
    send(29'h100_0000, 32'h0,         4'b0000, 32'h0,         1'b1, a1);
    chk("err_b2b_spacing", 32'(a1 - a0), 32'd1);

    // Back-to-back writes: one transaction every IC+1 cycles
    send(29'h000_0010, 32'hAAAA_0001, 4'b1111, 32'h0, 1'b0, a0);
    send(29'h000_0011, 32'hAAAA_0002, 4'b0011, 32'h0, 1'b0, a1);
    send(29'h000_0412, 32'hAAAA_0003, 4'b1100, 32'h0, 1'b0, a2);
    chk("b2b_spacing_1", 32'(a1 - a0), 32'(IC + 1));
    chk("b2b_spacing_2", 32'(a2 - a1), 32'(IC + 1));

    // Backpressure with a pending request held during it
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    send(29'h000_0401, 32'h0, 4'b0000, 32'hD000_0401, 1'b0, a0);
    req_valid = 1'b1;
    req_addr  = 29'h000_0402;
    req_wdata = 32'h0000_0077;
    req_wren  = 4'b1111;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_resp_seen", {31'b0, got}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    a1 = cyc;
    send(29'h000_0402, 32'h0000_0077, 4'b1111, 32'h0, 1'b0, a2);
    chk("bp_accept_cycle", 32'(a2), 32'(a1));

    // Reset during the final issue cycle of a write
    send(29'h000_0405, 32'h5555_AAAA, 4'b0110, 32'h0, 1'b0, a0);
    repeat (IC - 1) @(posedge clk);
    #2;
    chk("pre_rst_wren", {28'b0, mmio_wren}, 32'h6);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wren", {28'b0, mmio_wren}, 32'd0);
    chk("rst_async_addr", {3'b0, mmio_addr}, {3'b0, IDLE});
    exp_mmio.delete();
    exp_resp.delete();
    seen = 1'b0;
    exp_busy -= 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(29'h000_0000, 32'h0, 4'b0000, 32'hCAFE_0001, 1'b0, a0);
    send(29'h000_0406, 32'h0000_0042, 4'b0001, 32'h0, 1'b0, a0);

    // Drain and final accounting
    for (int i = 0; i < 100; i++) begin
      if (exp_resp.size() == 0 && exp_mmio.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("pending_resp", 32'(exp_resp.size()), 32'd0);
    chk("pending_wren", 32'(exp_mmio.size()), 32'd0);
    chk("mmio_busy_cycles", 32'(busy_cnt), 32'(exp_busy));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
